// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Fetch/execute sequencer for a small 32-word program ROM. Fetches a 16-bit
//   instruction into the IR, presents it for one EXEC cycle, then advances the
//   program counter (sequential, taken branch, or stop -> HALT). Supports free
//   run (one instruction per two cycles) and single-step via a button edge.
//
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   start           : level; launches execution from IDLE or HALT
//   step_mode       : 1 = single step, 0 = free run
//   step_btn        : debounced step button level (edge detected here)
//   rom_data        : instruction word for rom_addr (combinational ROM)
//   branch          : current instruction is a branch
//   branch_cond     : branch condition true
//   branch_target   : branch destination address
//   stop            : current instruction is a stop
//   rom_addr        : ROM address (always equals pc)
//   instruction     : instruction register
//   instr_valid     : high during the EXEC cycle
//   pc              : program counter
//   halted          : high in HALT
//   instr_count     : executed-instruction count, saturating
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step_btn,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              branch,
  input  logic              branch_cond,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              stop,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WAIT  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                step_q, step_d;
  logic                step_edge;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // The step button is sampled every cycle, so an edge that occurs outside
  // WAIT is consumed by step_q and never seen later.
  assign step_edge = step_btn & ~step_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    step_d  = step_btn;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_d    = rom_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        cnt_d = sat_inc(cnt_q);
        // stop outranks a taken branch; pc is left untouched on stop
        if (stop) begin
          state_d = S_HALT;
        end else begin
          if (branch && branch_cond) pc_d = branch_target;
          else                       pc_d = pc_q + 1'b1;
          state_d = step_mode ? S_WAIT : S_FETCH;
        end
      end
      S_WAIT: begin
        if (step_edge || !step_mode) state_d = S_FETCH;
      end
      S_HALT: begin
        if (start) begin
          pc_d    = '0;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
    end
  end

  assign rom_addr    = pc_q;
  assign pc          = pc_q;
  assign instruction = ir_q;
  assign instr_count = cnt_q;
  assign instr_valid = (state_q == S_EXEC);
  assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Scoreboard bench for instr_fetch. The bench plays the ROM, controller and
//   ALU: opcode 3'b101 is a branch, 3'b111 a stop (a stop with bit 1 set also
//   raises branch), branch_cond is instruction bit 0, target is bits [12:8].
//   A program-level model walks the ROM to produce the executed sequence;
//   a monitor compares each EXEC cycle against the queued expectations.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset, start, step_mode, step_btn;
  logic [15:0] rom_data, instruction;
  logic        branch, branch_cond, stop;
  logic [4:0]  branch_target, rom_addr, pc;
  logic        instr_valid, halted;
  logic [7:0]  instr_count;

  logic [15:0] rom [32];

  typedef struct {
    logic [4:0]  pc;
    logic [15:0] ins;
    logic [7:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc = 0;
  int prev_cyc = 0;
  int run_id = 0;
  int mon_run = 0;
  int exec_seen = 0;
  bit gap_chk = 1'b0;
  bit rnd_btn = 1'b0;

  function automatic bit is_stop(input logic [15:0] w);
    return w[15:13] == 3'b111;
  endfunction

  function automatic bit is_branch(input logic [15:0] w);
    return (w[15:13] == 3'b101) || (is_stop(w) && w[1]);
  endfunction

  assign rom_data      = rom[rom_addr];
  assign stop          = is_stop(instruction);
  assign branch        = is_branch(instruction);
  assign branch_cond   = instruction[0];
  assign branch_target = instruction[12:8];

  instr_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .step_mode    (step_mode),
    .step_btn     (step_btn),
    .rom_data     (rom_data),
    .branch       (branch),
    .branch_cond  (branch_cond),
    .branch_target(branch_target),
    .stop         (stop),
    .rom_addr     (rom_addr),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .halted       (halted),
    .instr_count  (instr_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, required 'h%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Program-level reference: walk the ROM from address 0 and queue what each
  // EXEC cycle must show. The count shown during an EXEC is the number of
  // instructions completed before it.
  task automatic model_run(input int max_exec, output bit halts,
                           output logic [4:0] hpc, output logic [15:0] hins,
                           output logic [7:0] hcnt);
    int   p;
    exp_t e;
    p = 0; halts = 1'b0; hpc = '0; hins = '0; hcnt = '0;
    for (int n = 0; n < max_exec; n++) begin
      e.pc  = p[4:0];
      e.ins = rom[p];
      e.cnt = (n >= 255) ? 8'd255 : n[7:0];
      exp_q.push_back(e);
      hins = rom[p];
      if (is_stop(rom[p])) begin
        halts = 1'b1;
        hpc   = p[4:0];
        hcnt  = (n >= 254) ? 8'd255 : 8'(n + 1);
        break;
      end
      if (is_branch(rom[p]) && rom[p][0]) p = int'(rom[p][12:8]);
      else                                p = (p + 1) % 32;
    end
  endtask

  function automatic logic [15:0] rand_ins();
    logic [15:0] w;
    int k, op;
    w = 16'($urandom);
    k = $urandom_range(0, 9);
    if (k == 6 || k == 7) w[15:13] = 3'b101;
    else if (k == 8)      w[15:13] = 3'b111;
    else begin
      op = $urandom_range(0, 5);
      if (op == 5) op = 6;
      w[15:13] = 3'(op);
    end
    return w;
  endfunction

  // Monitor: every EXEC cycle pops one expectation.
  always @(negedge clk) begin
    if (instr_valid) begin
      chk("exec_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("exec_pc", 32'(pc), 32'(mon_e.pc));
        chk("exec_rom_addr", 32'(rom_addr), 32'(mon_e.pc));
        chk("exec_ir", 32'(instruction), 32'(mon_e.ins));
        chk("exec_count", 32'(instr_count), 32'(mon_e.cnt));
      end
      if (mon_run != run_id) chk("first_exec_latency", 32'(cyc - start_cyc), 32'd1);
      else if (gap_chk)      chk("exec_gap", 32'(cyc - prev_cyc), 32'd2);
      mon_run  = run_id;
      prev_cyc = cyc;
      exec_seen++;
    end
  end

  task automatic do_reset();
    reset = 1'b1; start = 1'b1; step_btn = 1'b1;
    @(posedge clk); #1;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_ir", 32'(instruction), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    chk("rst_pending_execs", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    reset = 1'b0; start = 1'b0; step_btn = 1'b0;
  endtask

  task automatic start_run(input bit smode, input int max_exec, output bit h,
                           output logic [4:0] hpc, output logic [15:0] hins,
                           output logic [7:0] hcnt);
    step_mode = smode;
    model_run(max_exec, h, hpc, hins, hcnt);
    run_id++;
    gap_chk = !smode;
    start = 1'b1;
    @(posedge clk); #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (halted) break;
      @(negedge clk);
      if (rnd_btn) step_btn = 1'($urandom_range(0, 1));
    end
    chk("halt_reached", 32'(halted), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      if (rnd_btn) step_btn = 1'($urandom_range(0, 1));
    end
    chk("drain_execs", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_halt(input logic [4:0] hpc, input logic [15:0] hins,
                            input logic [7:0] hcnt);
    wait_halt(400);
    chk("halt_pc", 32'(pc), 32'(hpc));
    chk("halt_ir", 32'(instruction), 32'(hins));
    chk("halt_count", 32'(instr_count), 32'(hcnt));
    repeat (3) begin
      @(negedge clk);
      step_btn = 1'($urandom_range(0, 1));
    end
    chk("hold_pc", 32'(pc), 32'(hpc));
    chk("hold_ir", 32'(instruction), 32'(hins));
    chk("hold_count", 32'(instr_count), 32'(hcnt));
    chk("hold_halted", 32'(halted), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          h, found;
    logic [4:0]  hpc;
    logic [15:0] hins;
    logic [7:0]  hcnt;
    int          base, len, gap;

    reset = 1'b1; start = 1'b0; step_mode = 1'b0; step_btn = 1'b0;
    for (int a = 0; a < 32; a++) rom[a] = {3'b000, 5'(a), 8'(a)};
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();

    // Idle after reset: nothing may execute without start.
    repeat (6) begin
      @(negedge clk);
      step_btn = 1'($urandom_range(0, 1));
    end
    step_btn = 1'b0;
    chk("idle_pc", 32'(pc), 32'd0);
    chk("idle_valid", 32'(instr_valid), 32'd0);

    // Free run: four plain instructions then stop.
    rom[0] = 16'h1000; rom[1] = 16'h2111; rom[2] = 16'h4222; rom[3] = 16'h6333;
    rom[4] = 16'hE000;
    start_run(1'b0, 50, h, hpc, hins, hcnt);
    check_halt(hpc, hins, hcnt);
    chk("freerun_halt_pc", 32'(pc), 32'd4);
    chk("freerun_count", 32'(instr_count), 32'd5);

    // Restart from HALT clears pc and count.
    start_run(1'b0, 50, h, hpc, hins, hcnt);
    check_halt(hpc, hins, hcnt);

    // Taken and not-taken branch at address 2.
    for (int a = 0; a < 32; a++) rom[a] = {3'b000, 5'(a), 8'(a)};
    rom[2] = 16'hA501; rom[6] = 16'hE000;
    start_run(1'b0, 50, h, hpc, hins, hcnt);
    check_halt(hpc, hins, hcnt);
    rom[2] = 16'hA500;
    start_run(1'b0, 50, h, hpc, hins, hcnt);
    check_halt(hpc, hins, hcnt);

    // Stop together with a taken branch: stop wins, pc held.
    rom[2] = 16'h4222; rom[3] = 16'hE703;
    start_run(1'b0, 50, h, hpc, hins, hcnt);
    check_halt(hpc, hins, hcnt);
    chk("stop_branch_pc", 32'(pc), 32'd3);

    // Single step, starting from HALT.
    for (int a = 0; a < 32; a++) rom[a] = {3'b000, 5'(a), 8'(a)};
    rom[3] = 16'hA901; rom[12] = 16'hE000;
    base = exec_seen;
    start_run(1'b1, 50, h, hpc, hins, hcnt);
    step_btn = 1'b1;                       // rising edge during FETCH
    repeat (6) @(negedge clk);
    chk("step_fetch_edge_ignored", 32'(exec_seen - base), 32'd1);
    step_btn = 1'b0;
    start = 1'b1;                          // start in WAIT does nothing
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("step_start_ignored", 32'(exec_seen - base), 32'd1);
    chk("step_wait_pc", 32'(pc), 32'd1);
    for (int i = 0; i < 6; i++) begin
      len = (i == 0) ? 10 : $urandom_range(1, 10);
      gap = $urandom_range(3, 5);
      step_btn = 1'b1;
      repeat (len) @(negedge clk);
      step_btn = 1'b0;
      repeat (gap) @(negedge clk);
      chk("step_one_exec", 32'(exec_seen - base), 32'(i + 2));
    end
    step_mode = 1'b0;                      // leaving step mode resumes from WAIT
    check_halt(hpc, hins, hcnt);
    chk("step_halt_pc", 32'(pc), 32'd12);

    // Reset in the middle of EXEC at pc = 7.
    for (int a = 0; a < 32; a++) rom[a] = {3'b000, 5'(a), 8'(a)};
    start_run(1'b0, 8, h, hpc, hins, hcnt);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (instr_valid && pc == 5'd7) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_pc7", 32'(found), 32'd1);
    do_reset();
    repeat (4) @(negedge clk);

    // Wrap past 31 and saturate the counter.
    start_run(1'b0, 300, h, hpc, hins, hcnt);
    rnd_btn = 1'b1;
    wait_drain(800);
    chk("saturated_count", 32'(instr_count), 32'd255);
    do_reset();

    // Randomized programs in free run.
    for (int r = 0; r < 25; r++) begin
      for (int a = 0; a < 32; a++) rom[a] = rand_ins();
      start_run(1'b0, 60, h, hpc, hins, hcnt);
      if (h) check_halt(hpc, hins, hcnt);
      else begin
        wait_drain(300);
        do_reset();
      end
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        do_reset();
      end
    end
    rnd_btn = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
